// File: rtl/ball_ctrl.sv
// Pong ball controller.
// The ball moves by one 4-pixel step per axis once per video frame. It bounces off
// the right wall and off the top and bottom walls, and off the left paddle. When it
// reaches the left edge without touching the paddle, that is a miss. A miss puts
// the ball back at the centre and starts a 60-frame serve delay.
// BitRaster marks the pixels covered by the ball. It is registered and follows
// pixel/line one clock later.
module ball_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       VSync,
  input  logic [8:0] line,
  input  logic [9:0] pixel,
  input  logic [8:0] PaddlePosY,
  output logic       BitRaster,
  output logic [9:0] BallPosX,
  output logic [8:0] BallPosY,
  output logic [7:0] Score,
  output logic [7:0] Misses,
  output logic       Serving
);

  typedef enum logic [2:0] {
    WAIT_VS    = 3'd0,
    MOVE_X     = 3'd1,
    MOVE_Y     = 3'd2,
    CHECK      = 3'd3,
    LOAD       = 3'd4,
    SERVE      = 3'd5,
    SERVE_LOAD = 3'd6
  } state_t;

  localparam logic [9:0] START_X = 10'd320;
  localparam logic [8:0] START_Y = 9'd240;

  state_t     state, state_next;
  logic [9:0] ball_x, ball_x_next;
  logic [8:0] ball_y, ball_y_next;
  logic       dir_x, dir_x_next;
  logic       dir_y, dir_y_next;
  logic [7:0] score, score_next;
  logic [7:0] misses, misses_next;
  logic [5:0] serve_cnt, serve_cnt_next;
  logic [5:0] serve_cnt_inc;
  logic       bit_raster;
  logic       in_ball;
  logic       hit;

  // Vertical values are widened to 10 bits so that y+8 and pad+80 keep their carry.
  logic [9:0] ball_y_w, pad_w, line_w;
  assign ball_y_w      = {1'b0, ball_y};
  assign pad_w         = {1'b0, PaddlePosY};
  assign line_w        = {1'b0, line};
  assign serve_cnt_inc = serve_cnt + 6'd1;

  // The ball is moving left and overlaps the paddle face, both horizontally and vertically.
  assign hit = !dir_x && (ball_x >= 10'd44) && (ball_x <= 10'd50) &&
               (ball_y_w + 10'd8 > pad_w) && (ball_y_w < pad_w + 10'd80);

  // The current raster position lies inside the 8x8 ball square.
  assign in_ball = (pixel >= ball_x) && (pixel < ball_x + 10'd8) &&
                   (line_w >= ball_y_w) && (line_w < ball_y_w + 10'd8);

  // State and datapath registers; reset aborts immediately to the centre serve position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WAIT_VS;
      ball_x     <= START_X;
      ball_y     <= START_Y;
      dir_x      <= 1'b0;
      dir_y      <= 1'b1;
      score      <= '0;
      misses     <= '0;
      serve_cnt  <= '0;
      bit_raster <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the values from before this edge.
      state      <= state_next;
      ball_x     <= ball_x_next;
      ball_y     <= ball_y_next;
      dir_x      <= dir_x_next;
      dir_y      <= dir_y_next;
      score      <= score_next;
      misses     <= misses_next;
      serve_cnt  <= serve_cnt_next;
      bit_raster <= in_ball;
    end
  end

  // Next-state and datapath update: one ball step per frame, or waiting out the serve delay.
  always_comb begin
    // NOTE: defaults first, so that no path through the case statement infers a latch.
    state_next     = state;
    ball_x_next    = ball_x;
    ball_y_next    = ball_y;
    dir_x_next     = dir_x;
    dir_y_next     = dir_y;
    score_next     = score;
    misses_next    = misses;
    serve_cnt_next = serve_cnt;
    Serving        = 1'b0;

    case (state)
      WAIT_VS: begin
        if (!VSync) state_next = MOVE_X;
      end
      MOVE_X: begin
        if (dir_x) begin
          if (ball_x >= 10'd620) begin
            ball_x_next = 10'd624;
            dir_x_next  = 1'b0;
          end else begin
            ball_x_next = ball_x + 10'd4;
          end
        end else begin
          // The left edge does not bounce: a ball that reaches x=0 is judged in CHECK.
          if (ball_x < 10'd4) ball_x_next = '0;
          else                ball_x_next = ball_x - 10'd4;
        end
        state_next = MOVE_Y;
      end
      MOVE_Y: begin
        if (dir_y) begin
          if (ball_y >= 9'd452) begin
            ball_y_next = 9'd456;
            dir_y_next  = 1'b0;
          end else begin
            ball_y_next = ball_y + 9'd4;
          end
        end else begin
          if (ball_y <= 9'd20) begin
            ball_y_next = 9'd16;
            dir_y_next  = 1'b1;
          end else begin
            ball_y_next = ball_y - 9'd4;
          end
        end
        state_next = CHECK;
      end
      CHECK: begin
        // A hit takes priority over a miss, and any wall bounce from MOVE_Y is kept.
        if (hit) begin
          dir_x_next = 1'b1;
          score_next = score + 8'd1;
          state_next = LOAD;
        end else if (ball_x == 10'd0) begin
          misses_next    = misses + 8'd1;
          ball_x_next    = START_X;
          ball_y_next    = START_Y;
          dir_x_next     = 1'b0;
          dir_y_next     = 1'b1;
          serve_cnt_next = '0;
          state_next     = SERVE_LOAD;
        end else begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        // Wait for VSync to go high again so the ball moves only once per frame.
        if (VSync) state_next = WAIT_VS;
      end
      SERVE_LOAD: begin
        Serving = 1'b1;
        if (VSync) state_next = SERVE;
      end
      SERVE: begin
        Serving = 1'b1;
        if (!VSync) begin
          serve_cnt_next = serve_cnt_inc;
          state_next     = (serve_cnt_inc == 6'd60) ? WAIT_VS : SERVE_LOAD;
        end
      end
      default: state_next = WAIT_VS;
    endcase
  end

  assign BitRaster = bit_raster;
  assign BallPosX  = ball_x;
  assign BallPosY  = ball_y;
  assign Score     = score;
  assign Misses    = misses;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl. The reference model advances one whole frame at a time,
// using the rules for ball motion, paddle hits, misses and the serve delay.
// The bench checks the outputs after every frame and probes BitRaster at random
// raster positions.
module tb_ball_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       VSync;
  logic [8:0] line;
  logic [9:0] pixel;
  logic [8:0] PaddlePosY;
  logic       BitRaster;
  logic [9:0] BallPosX;
  logic [8:0] BallPosY;
  logic [7:0] Score;
  logic [7:0] Misses;
  logic       Serving;

  int tests = 0;
  int fails = 0;

  // Frame-level reference state
  int m_x, m_y, m_dx, m_dy, m_score, m_misses, m_serving, m_cnt;
  bit force_hit;

  ball_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .VSync      (VSync),
    .line       (line),
    .pixel      (pixel),
    .PaddlePosY (PaddlePosY),
    .BitRaster  (BitRaster),
    .BallPosX   (BallPosX),
    .BallPosY   (BallPosY),
    .Score      (Score),
    .Misses     (Misses),
    .Serving    (Serving)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic bit model_in_ball(int px, int ly);
    return (px >= m_x) && (px < m_x + 8) && (ly >= m_y) && (ly < m_y + 8);
  endfunction

  task automatic model_reset();
    m_x = 320; m_y = 240; m_dx = 0; m_dy = 1;
    m_score = 0; m_misses = 0; m_serving = 0; m_cnt = 0;
  endtask

  // Apply one frame's worth of rules to the model.
  task automatic model_frame();
    int  pad;
    bit  hit;
    pad = int'(PaddlePosY);
    if (m_serving != 0) begin
      m_cnt = m_cnt + 1;
      if (m_cnt != 60) return;
      m_serving = 0;
    end
    if (m_dx != 0) begin
      if (m_x >= 620) begin m_x = 624; m_dx = 0; end
      else m_x = m_x + 4;
    end else begin
      m_x = (m_x < 4) ? 0 : m_x - 4;
    end
    if (m_dy != 0) begin
      if (m_y >= 452) begin m_y = 456; m_dy = 0; end
      else m_y = m_y + 4;
    end else begin
      if (m_y <= 20) begin m_y = 16; m_dy = 1; end
      else m_y = m_y - 4;
    end
    hit = force_hit || ((m_dx == 0) && (m_x >= 44) && (m_x <= 50) &&
                        (m_y + 8 > pad) && (m_y < pad + 80));
    if (hit) begin
      m_dx = 1;
      m_score = (m_score + 1) % 256;
    end else if (m_x == 0) begin
      m_misses = (m_misses + 1) % 256;
      m_x = 320; m_y = 240; m_dx = 0; m_dy = 1;
      m_cnt = 0; m_serving = 1;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " x"},       BallPosX, m_x);
    check({tag, " y"},       BallPosY, m_y);
    check({tag, " score"},   Score,    m_score);
    check({tag, " misses"},  Misses,   m_misses);
    check({tag, " serving"}, Serving,  m_serving);
  endtask

  // One VSync low/high frame. The high phase probes BitRaster against the model.
  task automatic run_frame(input int low_len, input int high_len);
    int px, ly;
    bit exp_now, exp_prev;
    exp_prev = 1'b0;
    VSync = 1'b0;
    repeat (low_len) @(negedge clk);
    model_frame();
    VSync = 1'b1;
    for (int i = 0; i < high_len; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        px = clampi(m_x + int'($urandom_range(0, 12)) - 2, 0, 639);
        ly = clampi(m_y + int'($urandom_range(0, 12)) - 2, 0, 479);
      end else begin
        px = int'($urandom_range(0, 639));
        ly = int'($urandom_range(0, 479));
      end
      pixel   = px[9:0];
      line    = ly[8:0];
      exp_now = model_in_ball(px, ly);
      if (i > 0) begin
        #1;
        check("raster probe", BitRaster, exp_prev);
      end
      exp_prev = exp_now;
      @(negedge clk);
    end
    check_state("frame");
  endtask

  task automatic run_rand_frame();
    run_frame(int'($urandom_range(6, 12)), int'($urandom_range(2, 8)));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    VSync = 1'b1;
    #1;
    check("reset x",       BallPosX,  320);
    check("reset y",       BallPosY,  240);
    check("reset score",   Score,     0);
    check("reset misses",  Misses,    0);
    check("reset serving", Serving,   0);
    check("reset raster",  BitRaster, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    bit exp_prev, exp_now;
    int pad;
    force_hit  = 1'b0;
    reset      = 1'b1;
    VSync      = 1'b1;
    pixel      = '0;
    line       = '0;
    PaddlePosY = 9'd384;
    #1;
    do_reset();

    // A single long low pulse still gives exactly one step.
    run_frame(100, 4);
    check("long low x",     BallPosX, 316);
    check("long low y",     BallPosY, 244);
    check("long low score", Score,    0);

    // Raster sweep around the centre ball with one-clock latency.
    do_reset();
    pixel = 10'd0; line = 9'd0;
    @(negedge clk);
    exp_prev = 1'b0;
    for (int l = 236; l < 252; l++) begin
      for (int p = 316; p < 332; p++) begin
        pixel   = p[9:0];
        line    = l[8:0];
        exp_now = (p >= 320) && (p < 328) && (l >= 240) && (l < 248);
        #1;
        check("sweep raster", BitRaster, exp_prev);
        exp_prev = exp_now;
        @(negedge clk);
      end
    end

    // Bottom bounce, then a paddle hit at frame 68.
    do_reset();
    PaddlePosY = 9'd384;
    for (int f = 1; f <= 68; f++) begin
      run_rand_frame();
      if (f == 54) begin
        check("bounce y",    BallPosY,  456);
        check("bounce diry", dut.dir_y, 0);
      end
    end
    check("hit x",     BallPosX,  48);
    check("hit y",     BallPosY,  400);
    check("hit score", Score,     1);
    check("hit dirx",  dut.dir_x, 1);

    // Missed paddle, then the serve delay.
    do_reset();
    PaddlePosY = 9'd16;
    for (int f = 1; f <= 80; f++) begin
      run_rand_frame();
      if (f == 68) check("no hit score", Score, 0);
    end
    check("miss misses",  Misses,   1);
    check("miss x",       BallPosX, 320);
    check("miss y",       BallPosY, 240);
    check("miss serving", Serving,  1);
    for (int k = 1; k <= 60; k++) begin
      run_rand_frame();
      if (k == 59) check("serve held", Serving, 1);
    end
    check("serve done serving", Serving,  0);
    check("serve done x",       BallPosX, 316);
    check("serve done y",       BallPosY, 244);

    // Reset in the middle of a serve delay.
    do_reset();
    PaddlePosY = 9'd16;
    repeat (80) run_rand_frame();
    repeat (30) run_rand_frame();
    check("mid serve cnt",     dut.serve_cnt, 30);
    check("mid serve serving", Serving,       1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort x",       BallPosX,  320);
    check("abort y",       BallPosY,  240);
    check("abort score",   Score,     0);
    check("abort misses",  Misses,    0);
    check("abort serving", Serving,   0);
    check("abort raster",  BitRaster, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    run_rand_frame();
    check("after abort x", BallPosX, 316);
    check("after abort y", BallPosY, 244);

    // Score wrap: forced hits drive the score up to 255, then one more hit wraps it to 0.
    do_reset();
    force dut.hit = 1'b1;
    force_hit = 1'b1;
    repeat (255) run_rand_frame();
    check("preload score", Score, 255);
    run_rand_frame();
    check("wrap score",  Score,  0);
    check("wrap misses", Misses, 0);
    release dut.hit;
    force_hit = 1'b0;

    // Random play. The paddle is often placed near the ball, so both hits and misses occur.
    do_reset();
    for (int f = 0; f < 200; f++) begin
      if ($urandom_range(0, 1) == 1) begin
        pad = clampi(m_y - int'($urandom_range(0, 90)) + 6, 0, 400);
      end else begin
        pad = int'($urandom_range(0, 400));
      end
      PaddlePosY = pad[8:0];
      run_rand_frame();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ball_ctrl.md
BALL_CTRL -- requirements
Module: ball_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on posedge clk.
REQ-002 reset  input  1  asynchronous, active-low; clears all state immediately on negedge, independent of clk.
REQ-003 VSync  input  1  frame sync; low pulse marks start of frame.
REQ-004 line  input  9  current raster line, 0..479.
REQ-005 pixel  input  10  current raster pixel, 0..639.
REQ-006 PaddlePosY  input  9  left paddle top line; paddle occupies lines PaddlePosY..PaddlePosY+79 and pixels 40..49.
REQ-007 BitRaster  output  1  registered; 1 when the current pixel lies inside the ball.
REQ-008 BallPosX  output  10  ball left edge, multiple of 4, range 0..624.
REQ-009 BallPosY  output  9  ball top edge, multiple of 4, range 16..456.
REQ-010 Score  output  8  paddle hit count, wraps 255->0.
REQ-011 Misses  output  8  missed-ball count, wraps 255->0.
REQ-012 Serving  output  1  high while the serve delay runs.

Function
REQ-013 Ball SHALL be 8x8 pixels; step SHALL be 4 px per frame on each axis; direction flags DirX (1=right) and DirY (1=down).
REQ-014 FSM states SHALL be WaitVS, MoveX, MoveY, Check, Load, Serve, ServeLoad; one transition per clk except where a state waits.
REQ-015 WaitVS: go to MoveX when VSync==0, else stay.
REQ-016 MoveX, right: if BallPosX>=620 then BallPosX=624, DirX=0; else BallPosX+4; next MoveY.
REQ-017 MoveX, left: if BallPosX<4 then BallPosX=0; else BallPosX-4; next MoveY.
REQ-018 MoveY, down: if BallPosY>=452 then BallPosY=456, DirY=0; else BallPosY+4; next Check.
REQ-019 MoveY, up: if BallPosY<=20 then BallPosY=16, DirY=1; else BallPosY-4; next Check.
REQ-020 Check, hit: when DirX==0, 44<=BallPosX<=50, BallPosY+8>PaddlePosY and BallPosY<PaddlePosY+80, set DirX=1, Score+1, next Load.
REQ-021 Check, miss: when there is no hit and BallPosX==0, set Misses+1, BallPosX=320, BallPosY=240, DirX=0, DirY=1, ServeCnt=0, next ServeLoad.
REQ-022 Check, otherwise: go to Load.
REQ-023 Hit SHALL take priority over miss; a Y wall bounce and a paddle hit in the same frame SHALL both take effect.
REQ-024 Load: go to WaitVS when VSync==1, else stay; this limits ball updates to exactly one per frame.
REQ-025 ServeLoad: go to Serve when VSync==1.
REQ-026 Serve: when VSync==0, increment 6-bit ServeCnt; if the new value is 60, go to WaitVS; otherwise go to ServeLoad.
REQ-027 During Serve and ServeLoad, the ball SHALL NOT move and Serving SHALL be 1; Serving SHALL be 0 in all other states.
REQ-028 Arithmetic SHALL use 10-bit widths internally: BallPosX+8, PaddlePosY+80 and BallPosY+8 SHALL NOT truncate.
REQ-029 BitRaster SHALL be registered, with 1-clk latency from pixel/line.
REQ-030 BitRaster SHALL be 1 iff BallPosX<=pixel<BallPosX+8 and BallPosY<=line<BallPosY+8, using the positions current at that clk.
REQ-031 An unused FSM encoding SHALL go to WaitVS.

Reset
REQ-032 On reset low: state=WaitVS, BallPosX=320, BallPosY=240, DirX=0, DirY=1, Score=0, Misses=0, ServeCnt=0, Serving=0, BitRaster=0.
REQ-033 Reset asserted mid-frame or mid-serve SHALL abort immediately to the REQ-032 values; the first move after release waits for VSync==0.

Verification
REQ-034 Reset release, one VSync low/high frame -> BallPosX=316, BallPosY=244, Score=0; VSync held low 100 clks -> exactly one update.
REQ-035 PaddlePosY=384, run 68 frames -> frame 54 bounce at BallPosY=456 (DirY=0); frame 68 BallPosX=48, BallPosY=400, Score=1, DirX=1.
REQ-036 PaddlePosY=16, run 80 frames -> no hit at frame 68; frame 80 Misses=1, ball at 320/240, Serving=1; Serving stays 1 for 60 frames, then motion resumes with BallPosX=316.
REQ-037 Ball at 320/240, raster sweep -> BitRaster=1 exactly for pixel 320..327 and line 240..247, one clk after the inputs.
REQ-038 Assert reset during Serve at ServeCnt=30 -> all outputs at REQ-032 values on the same edge; Misses=0.
REQ-039 Score=255 preloaded via 255 forced hits, one further hit -> Score=0, no other side effects.
